ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-002 in_valid  in  1  ID/EX slot holds a valid instruction.
REQ-003 wb_ctl  in  2, m_ctl  in  3  WB/MEM control from ID/EX.
REQ-004 regdst  in  1, alusrc  in  1, aluop  in  2  EX control from ID/EX.
REQ-005 npc, rdata1, rdata2, sign_ext  in  32 each  ID/EX datapath.
REQ-006 rt, rd  in  5 each  candidate destination fields.
REQ-007 fwd_a_sel, fwd_b_sel  in  2 each  forwarding select: 00 register, 01 exmem_fwd, 10 memwb_fwd, 11 register.
REQ-008 exmem_fwd, memwb_fwd  in  32 each  forwarded results.
REQ-009 flush  in  1  kill the instruction entering EX/MEM.
REQ-010 mem_stall  in  1  downstream hold.
REQ-011 stall_req  out  1  EX busy; upstream holds ID/EX.
REQ-012 out_valid  out  1, wb_ctlout  out  2, m_ctlout  out  3  registered EX/MEM control.
REQ-013 alu_result, wdata, branch_target  out  32 each; zero  out  1; dest_reg  out  5  registered EX/MEM datapath.

Function
REQ-014 Operand A = fwd_a_sel mux; operand B_fwd = fwd_b_sel mux; operand B = alusrc ? sign_ext : B_fwd; wdata captures B_fwd.
REQ-015 ALU op: aluop 00 add; 01 sub; 11 slt; 10 decode sign_ext[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x18 mult; other funct -> result 0.
REQ-016 add/sub wrap modulo 2^32; slt signed, result 1 or 0; zero = (result == 0).
REQ-017 branch_target = npc + (sign_ext << 2), modulo 2^32; dest_reg = regdst ? rd : rt.
REQ-018 hold = mem_stall | stall_req; EX/MEM register updates on rising clk only when hold = 0 or flush = 1.
REQ-019 flush has priority over hold: next edge out_valid=0, wb_ctlout=0, m_ctlout=0; datapath outputs don't-care.
REQ-020 out_valid captures in_valid when updating; latency 1 cycle for non-mult ops.
REQ-021 mult FSM states IDLE, BUSY, DONE; only active with MUL_EN.
REQ-022 IDLE: in_valid & mult decoded -> latch A/B, stall_req=1 combinationally, counter=0, go BUSY.
REQ-023 BUSY: one shift-add iteration per cycle, stall_req=1; after 32 iterations go DONE.
REQ-024 DONE: stall_req=0, alu_result = low 32 bits of unsigned product; on edge with hold=0 capture and go IDLE; with mem_stall=1 remain DONE.
REQ-025 Mult timing: presented cycle 0, stall_req high cycles 0-32, product captured at edge ending cycle 33.
REQ-026 flush during BUSY or DONE aborts: FSM -> IDLE, stall_req=0 next cycle, result discarded.
REQ-027 Upstream holds ID/EX inputs constant while stall_req=1; inputs changing then are undefined behaviour.

Reset
REQ-028 reset asserted: all outputs 0, FSM IDLE, counter 0, operand latches 0, immediately without clk.
REQ-029 reset mid-multiply abandons the operation; first post-reset edge behaves as IDLE.

Configuration
REQ-030 Macro EX_STAGE_MUL_EN defined: multiplier FSM per REQ-021..026 compiled in.
REQ-031 EX_STAGE_MUL_EN undefined: no FSM, stall_req tied 0, funct 0x18 yields alu_result 0 at 1-cycle latency.

Verification
REQ-032 add: aluop=10, funct 0x20, rdata1=5, rdata2=7, fwd sel 00 -> next edge alu_result=12, zero=0, out_valid=1.
REQ-033 forwarding: fwd_a_sel=01, exmem_fwd=0x10, aluop=01, B=0x10 -> alu_result=0, zero=1; branch_target=npc+(sign_ext<<2).
REQ-034 flush with in_valid=1, mem_stall=1 -> next edge out_valid=0, wb_ctlout=0, m_ctlout=0.
REQ-035 MUL_EN: 7*6 -> stall_req high 33 cycles, alu_result=42 after 34th edge; 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-036 mem_stall=1 during DONE for 3 cycles -> outputs unchanged, stall_req=0, product captured on first edge after release.
REQ-037 reset asserted in BUSY iteration 10 -> outputs 0 immediately, stall_req=0; next add completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the five-stage pipeline.
//
// Selects forwarded operands, runs the ALU, computes the branch target and
// destination register, and holds the result in the EX/MEM pipeline register.
//
// Optional feature macro: EX_STAGE_MUL_EN
//   defined   -> a 32-cycle shift-add multiplier serves funct 0x18 and
//                stalls upstream while it works
//   undefined -> no multiplier, stall_req is tied low, funct 0x18 gives 0
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   in_valid                    ID/EX holds a valid instruction
//   wb_ctl, m_ctl               WB/MEM control carried to EX/MEM
//   regdst, alusrc, aluop       EX control
//   npc, rdata1, rdata2,
//   sign_ext                    ID/EX datapath values
//   rt, rd                      candidate destination register fields
//   fwd_a_sel, fwd_b_sel        00/11 register, 01 exmem_fwd, 10 memwb_fwd
//   exmem_fwd, memwb_fwd        forwarded results
//   flush                       kill the instruction entering EX/MEM
//   mem_stall                   downstream hold
//   stall_req                   EX busy, upstream must hold ID/EX
//   out_valid, wb_ctlout,
//   m_ctlout                    registered EX/MEM control
//   alu_result, wdata,
//   branch_target, zero,
//   dest_reg                    registered EX/MEM datapath
// ---------------------------------------------------------------------------
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] sign_ext,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [31:0] exmem_fwd,
  input  logic [31:0] memwb_fwd,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        stall_req,
  output logic        out_valid,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [31:0] alu_result,
  output logic [31:0] wdata,
  output logic [31:0] branch_target,
  output logic        zero,
  output logic [4:0]  dest_reg
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULT, ALU_NONE
  } aluFunc_t;

  logic [31:0] w_opA;
  logic [31:0] w_opBFwd;
  logic [31:0] w_opB;
  logic [31:0] w_aluResult;
  logic [31:0] w_multResult;
  logic [31:0] w_branchTarget;
  logic [4:0]  w_destReg;
  logic        w_hold;
  aluFunc_t    w_aluFunc;

  // Forwarding muxes; select 11 falls back to the register file value.
  always_comb begin
    w_opA = rdata1;
    case (fwd_a_sel)
      2'b01:   w_opA = exmem_fwd;
      2'b10:   w_opA = memwb_fwd;
      default: w_opA = rdata1;
    endcase
    w_opBFwd = rdata2;
    case (fwd_b_sel)
      2'b01:   w_opBFwd = exmem_fwd;
      2'b10:   w_opBFwd = memwb_fwd;
      default: w_opBFwd = rdata2;
    endcase
  end

  assign w_opB = alusrc ? sign_ext : w_opBFwd;

  // ALU control: aluop 10 means R-type, so the funct field in the low
  // immediate bits picks the operation.
  always_comb begin
    w_aluFunc = ALU_NONE;
    case (aluop)
      2'b00: w_aluFunc = ALU_ADD;
      2'b01: w_aluFunc = ALU_SUB;
      2'b11: w_aluFunc = ALU_SLT;
      default: begin
        case (sign_ext[5:0])
          6'h20:   w_aluFunc = ALU_ADD;
          6'h22:   w_aluFunc = ALU_SUB;
          6'h24:   w_aluFunc = ALU_AND;
          6'h25:   w_aluFunc = ALU_OR;
          6'h2A:   w_aluFunc = ALU_SLT;
          6'h18:   w_aluFunc = ALU_MULT;
          default: w_aluFunc = ALU_NONE;
        endcase
      end
    endcase
  end

  // ALU datapath; unknown functs produce zero.
  always_comb begin
    w_aluResult = 32'd0;
    case (w_aluFunc)
      ALU_ADD:  w_aluResult = w_opA + w_opB;
      ALU_SUB:  w_aluResult = w_opA - w_opB;
      ALU_AND:  w_aluResult = w_opA & w_opB;
      ALU_OR:   w_aluResult = w_opA | w_opB;
      ALU_SLT:  w_aluResult = {31'd0, $signed(w_opA) < $signed(w_opB)};
      ALU_MULT: w_aluResult = w_multResult;
      default:  w_aluResult = 32'd0;
    endcase
  end

  assign w_branchTarget = npc + {sign_ext[29:0], 2'b00};
  assign w_destReg      = regdst ? rd : rt;
  assign w_hold         = mem_stall | stall_req;

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  mulState_t   r_state;
  mulState_t   w_nextState;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_prod;
  logic [4:0]  r_count;
  logic        w_isMult;

  assign w_isMult     = (w_aluFunc == ALU_MULT);
  assign w_multResult = r_prod;

  // Multiplier control. A flushed multiply never starts, so it does not
  // freeze the front end. Reset gates stall_req so the pipeline is released
  // the moment reset is asserted, even if ID/EX still shows a multiply.
  always_comb begin
    w_nextState = r_state;
    stall_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && w_isMult && !flush) begin
          stall_req   = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (flush)
          w_nextState = IDLE;
        else if (r_count == 5'd31)
          w_nextState = DONE;
      end
      DONE: begin
        if (flush || !mem_stall)
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (reset)
      stall_req = 1'b0;
  end

  // Shift-add multiplier registers. Only the low 32 product bits are kept,
  // so the multiplicand can simply shift left within 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_prod   <= 32'd0;
      r_count  <= 5'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_nextState == BUSY) begin
        r_mcand  <= w_opA;
        r_mplier <= w_opB;
        r_prod   <= 32'd0;
        r_count  <= 5'd0;
      end else if (r_state == BUSY && !flush) begin
        if (r_mplier[0])
          r_prod <= r_prod + r_mcand;
        r_mcand  <= {r_mcand[30:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[31:1]};
        r_count  <= r_count + 5'd1;
      end
    end
  end
`else
  assign stall_req    = 1'b0;
  assign w_multResult = 32'd0;
`endif

  // EX/MEM pipeline register. Flush beats hold and clears only the control
  // bits; the datapath fields are don't-care for a killed slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      wb_ctlout     <= 2'd0;
      m_ctlout      <= 3'd0;
      alu_result    <= 32'd0;
      wdata         <= 32'd0;
      branch_target <= 32'd0;
      zero          <= 1'b0;
      dest_reg      <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      wb_ctlout <= 2'd0;
      m_ctlout  <= 3'd0;
    end else if (!w_hold) begin
      out_valid     <= in_valid;
      wb_ctlout     <= wb_ctl;
      m_ctlout      <= m_ctl;
      alu_result    <= w_aluResult;
      wdata         <= w_opBFwd;
      branch_target <= w_branchTarget;
      zero          <= (w_aluResult == 32'd0);
      dest_reg      <= w_destReg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- scoreboard bench for ex_stage.
//
// Directed vectors carry hand-computed results. Issuing a vector pushes its
// expected EX/MEM contents into a queue; an independent monitor pops and
// compares whenever a valid result is captured. Multiplier scenarios are
// exercised only when EX_STAGE_MUL_EN is defined.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  typedef struct {
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] npc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
    logic [31:0] exf;
    logic [31:0] mwf;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] expRes;
    logic        expZero;
    logic [31:0] expWdata;
    logic [31:0] expBt;
    logic [4:0]  expDest;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [31:0] wdata;
    logic [31:0] bt;
    logic [4:0]  dest;
    logic [1:0]  wb;
    logic [2:0]  m;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] sign_ext;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] exmem_fwd;
  logic [31:0] memwb_fwd;
  logic        flush;
  logic        mem_stall;
  logic        stall_req;
  logic        out_valid;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] alu_result;
  logic [31:0] wdata;
  logic [31:0] branch_target;
  logic        zero;
  logic [4:0]  dest_reg;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  vec_t vecs[11];
  logic pendingCapture = 1'b0;

  ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
    .sign_ext(sign_ext), .rt(rt), .rd(rd),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .exmem_fwd(exmem_fwd), .memwb_fwd(memwb_fwd),
    .flush(flush), .mem_stall(mem_stall), .stall_req(stall_req),
    .out_valid(out_valid), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
    .alu_result(alu_result), .wdata(wdata), .branch_target(branch_target),
    .zero(zero), .dest_reg(dest_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by monitor and directed checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one vector's fields onto the ID/EX inputs.
  task automatic driveVec(input vec_t v);
    aluop = v.aluop;  alusrc = v.alusrc;  regdst = v.regdst;
    fwd_a_sel = v.fa; fwd_b_sel = v.fb;   npc = v.npc;
    rdata1 = v.r1;    rdata2 = v.r2;      sign_ext = v.se;
    exmem_fwd = v.exf; memwb_fwd = v.mwf; rt = v.rt; rd = v.rd;
    wb_ctl = v.wb;    m_ctl = v.m;
  endtask

  task automatic pushExpected(input vec_t v);
    exp_t e;
    e.res = v.expRes; e.zero = v.expZero; e.wdata = v.expWdata;
    e.bt = v.expBt;   e.dest = v.expDest; e.wb = v.wb; e.m = v.m;
    expQ.push_back(e);
  endtask

  // Present one instruction for a single clock edge.
  task automatic applyStimulus(input vec_t v, input bit doPush);
    driveVec(v);
    in_valid = 1'b1;
    if (doPush) pushExpected(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One empty edge so a bubble lands in EX/MEM.
  task automatic idleCycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: an edge captures when nothing holds it (or flush forces it);
  // every captured valid result must match the oldest expectation.
  always @(negedge clk) begin
    if (pendingCapture && out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got result 0x%08h, expected no valid output", alu_result);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("alu_result", alu_result, e.res);
        checkOutput("zero", {31'd0, zero}, {31'd0, e.zero});
        checkOutput("wdata", wdata, e.wdata);
        checkOutput("branch_target", branch_target, e.bt);
        checkOutput("dest_reg", {27'd0, dest_reg}, {27'd0, e.dest});
        checkOutput("wb_ctlout", {30'd0, wb_ctlout}, {30'd0, e.wb});
        checkOutput("m_ctlout", {29'd0, m_ctlout}, {29'd0, e.m});
      end
    end
    pendingCapture = !reset && ((!mem_stall && !stall_req) || flush);
  end

`ifdef EX_STAGE_MUL_EN
  // Multiply a*b; optionally keep mem_stall high so the FSM waits in DONE.
  task automatic runMult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input bit withMemStall);
    vec_t v;
    int   stallCycles;
    v = vecs[10];
    v.r1 = a; v.r2 = b; v.expRes = prod;
    v.expZero = (prod == 32'd0); v.expWdata = b;
    idleCycle();
    driveVec(v);
    in_valid  = 1'b1;
    mem_stall = withMemStall;
    pushExpected(v);
    stallCycles = 0;
    @(negedge clk);
    while (stall_req && stallCycles < 100) begin
      stallCycles++;
      @(negedge clk);
    end
    checkOutput("mult_stall_cycles", stallCycles, 33);
    if (withMemStall) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("done_stall_req", {31'd0, stall_req}, 32'd0);
        checkOutput("done_held_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        if (i < 2) @(negedge clk);
      end
      mem_stall = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //                aluop  src  rdst fa     fb     npc           r1            r2            se            exf        mwf       rt    rd     wb    m     expRes        z     wdata         bt            dest
    vecs[0]  = '{2'b10, 1'b0, 1'b1, 2'b00, 2'b00, 32'h100,      32'd5,        32'd7,        32'h20,       32'h0,     32'h0,    5'd9,  5'd3,  2'd2, 3'd1, 32'd12,       1'b0, 32'd7,        32'h180,      5'd3};
    vecs[1]  = '{2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 32'h200,      32'h99,       32'h55,       32'h10,       32'h10,    32'h0,    5'd4,  5'd8,  2'd1, 3'd2, 32'd0,        1'b1, 32'h55,       32'h240,      5'd4};
    vecs[2]  = '{2'b10, 1'b0, 1'b1, 2'b10, 2'b01, 32'h1000,     32'd1,        32'd2,        32'h22,       32'd30,    32'd100,  5'd1,  5'd31, 2'd3, 3'd4, 32'd70,       1'b0, 32'd30,       32'h1088,     5'd31};
    vecs[3]  = '{2'b10, 1'b0, 1'b1, 2'b11, 2'b11, 32'h0,        32'hF0F01234, 32'h0FF0FF00, 32'h24,       32'hDEAD,  32'hBEEF, 5'd2,  5'd5,  2'd0, 3'd7, 32'h00F01200, 1'b0, 32'h0FF0FF00, 32'h90,       5'd5};
    vecs[4]  = '{2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40,       32'hF0000000, 32'h0000000F, 32'h25,       32'h0,     32'h0,    5'd6,  5'd7,  2'd2, 3'd0, 32'hF000000F, 1'b0, 32'h0000000F, 32'hD4,       5'd6};
    vecs[5]  = '{2'b10, 1'b0, 1'b1, 2'b00, 2'b00, 32'h10,       32'hFFFFFFFF, 32'd1,        32'h2A,       32'h0,     32'h0,    5'd0,  5'd10, 2'd1, 3'd1, 32'd1,        1'b0, 32'd1,        32'hB8,       5'd10};
    vecs[6]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 32'h1000,     32'd5,        32'h77,       32'hFFFFFFFE, 32'h0,     32'h0,    5'd12, 5'd13, 2'd2, 3'd2, 32'd0,        1'b1, 32'h77,       32'h0FF8,     5'd12};
    vecs[7]  = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd3,        32'd1,        32'h0,     32'h0,    5'd0,  5'd17, 2'd3, 3'd3, 32'd0,        1'b1, 32'd3,        32'h0,        5'd17};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 32'h300,      32'd0,        32'd1,        32'd0,        32'h0,     32'h0,    5'd20, 5'd21, 2'd1, 3'd5, 32'hFFFFFFFF, 1'b0, 32'd1,        32'h300,      5'd20};
    vecs[9]  = '{2'b10, 1'b0, 1'b1, 2'b00, 2'b00, 32'h80,       32'd9,        32'd9,        32'h3F,       32'h0,     32'h0,    5'd1,  5'd2,  2'd2, 3'd6, 32'd0,        1'b1, 32'd9,        32'h17C,      5'd2};
    vecs[10] = '{2'b10, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0,        32'd7,        32'd6,        32'h18,       32'h0,     32'h0,    5'd0,  5'd9,  2'd2, 3'd0, 32'd0,        1'b1, 32'd6,        32'h60,       5'd9};

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    driveVec(vecs[0]);

    // Reset state before any clock edge, then with a valid instruction applied.
    #2;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_alu_result", alu_result, 32'd0);
    checkOutput("reset_branch_target", branch_target, 32'd0);
    checkOutput("reset_stall_req", {31'd0, stall_req}, 32'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_hold_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_hold_wb", {30'd0, wb_ctlout}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;

    // Main ALU, forwarding and branch-target vectors, back to back.
    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i], 1'b1);

`ifndef EX_STAGE_MUL_EN
    // Without the multiplier, funct 0x18 is an ordinary 1-cycle zero result.
    applyStimulus(vecs[10], 1'b1);
    checkOutput("mult_off_latency", {31'd0, out_valid}, 32'd1);
    checkOutput("mult_off_stall", {31'd0, stall_req}, 32'd0);
`endif

    // mem_stall freezes EX/MEM; the held instruction lands on release.
    applyStimulus(vecs[0], 1'b1);
    driveVec(vecs[1]);
    in_valid  = 1'b1;
    mem_stall = 1'b1;
    pushExpected(vecs[1]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_result", alu_result, 32'd12);
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    mem_stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Flush beats mem_stall and clears the control bits of a valid slot.
    applyStimulus(vecs[2], 1'b1);
    driveVec(vecs[3]);
    in_valid  = 1'b1;
    mem_stall = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_wb_ctlout", {30'd0, wb_ctlout}, 32'd0);
    checkOutput("flush_m_ctlout", {29'd0, m_ctlout}, 32'd0);
    flush = 1'b0; mem_stall = 1'b0; in_valid = 1'b0;
    idleCycle();

`ifdef EX_STAGE_MUL_EN
    runMult(32'd7, 32'd6, 32'd42, 1'b0);
    runMult(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0);
    runMult(32'd7, 32'd6, 32'd42, 1'b1);

    // Reset in the middle of BUSY abandons the multiply.
    idleCycle();
    driveVec(vecs[10]);
    in_valid = 1'b1;
    repeat (11) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midmul_reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midmul_reset_result", alu_result, 32'd0);
    checkOutput("midmul_reset_stall", {31'd0, stall_req}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(vecs[0], 1'b1);
    checkOutput("post_reset_latency", {31'd0, out_valid}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
